pwm_in: RTL
===========

# pwm_in

Three-channel pulse-width capture peripheral on the 8-bit peripheral register bus, the input-side counterpart of the LED PWM output block. Each channel synchronises an external pin, measures high time and period in clock cycles, and publishes both as a consistent pair, together with valid and overflow flags, in bus-readable registers. Typical uses are reading back PWM pins, servo-style inputs and fan tachometers.

## Interface
- No parameters. Channel count (3) and counter width (8) are fixed by the address map.
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_en  in  1  read strobe, one cycle
- addr  in  5  register address, shared by read and write
- rd_data  out  8  read data, registered
- rd_valid  out  1  one-cycle pulse, the cycle after rd_en
- wr_en  in  1  write strobe, one cycle
- wr_data  in  8  write data
- pin  in  3  asynchronous inputs; bit n is channel n

## Operation
- Address map:
  - 0/4/8: HI of ch0/1/2 (RO)
  - 1/5/9: PER of ch0/1/2 (RO)
  - 12: STATUS, with VALID[2:0] and OVF[5:3]; write-1-to-clear; bits 7:6 read 0
  - 13: CTRL, with EN[2:0]; RW; bits 7:3 read 0, ignore writes
  - Other addresses: reads return 0, writes are ignored.
- Per channel, with EN=1:
  - Input path: 2-flop synchroniser to s, plus a delayed copy s_d. rise = s & ~s_d; fall = ~s & s_d.
  - cnt (8-bit) counts cycles since the last rise and saturates at 255, never wrapping.
  - On rise: cnt <= 1. If armed=1, publish: PER <= cnt, HI <= hi_run, VALID <= 1, OVF <= 1 if cnt==255 or hi_run==255. Then armed <= 1.
  - On fall: hi_run <= cnt.
  - Otherwise: cnt <= min(cnt+1, 255).
  - The first rise after reset or after enable only arms the channel; nothing is published.
  - Result: if s is high for H cycles and rises recur every P cycles, then HI=H and PER=P, each saturated at 255.
- EN=0: cnt, hi_run and armed are held at 0, and edges are ignored. HI, PER, VALID and OVF keep their values. The synchroniser keeps running.
- Status set/clear collision: if hardware sets a flag in the same cycle that software writes 1 to clear it, the set wins.
- Reads return HI and PER as they stand at the rd_en cycle. A publish in that same cycle is not visible until the next read.
- Read and write in the same cycle: the read returns the pre-write value.

## Timing
- Reset values:
  - rd_data=0, rd_valid=0
  - HI, PER, STATUS = 0
  - CTRL = 0x07 (all channels enabled)
  - sync flops, s_d, cnt, hi_run, armed = 0
- A pin held high through reset produces a rise 2 cycles after rst deasserts. That rise only arms the channel.
- Pin-to-edge latency: an edge is detected 2 clocks after the pin change is sampled. Published values appear 1 cycle after the rise cycle.
- Read latency: rd_data and rd_valid are valid exactly 1 cycle after rd_en. rd_valid is 0 in all other cycles. Back-to-back reads every cycle are supported.
- Writes take effect on the clock edge of the wr_en cycle. A CTRL change affects edge processing from the next cycle.
- rst asserted mid-operation forces every register to its reset value immediately, without waiting for a clock. Captures in progress are discarded.
- Minimum measurable: HI=1, PER=2. Pulses narrower than 1 clock may be missed.

## Test plan
- Reset: assert rst mid-capture, then release. Expect all reads to return 0 except CTRL=0x07, and rd_valid=0 until the first rd_en.
- Basic capture, ch0: square wave with HI=10 and PER=25 cycles, 3 periods. Expect addr 0 to read 10, addr 1 to read 25 and STATUS=0x01. The first period is not published: STATUS stays 0 until the 2nd rise.
- Saturation, ch1: high for 300 cycles, period 400. Expect HI=255, PER=255, STATUS=0x12. Then write 0x10 to addr 12 and expect STATUS=0x02.
- Collision, ch2: write 0x04 to addr 12 in the same cycle as a ch2 publish. Expect STATUS bit 2 to remain 1.
- Enable control:
  - Write 0x06 to CTRL while ch0 toggles (HI=5, PER=12). Expect HI and PER to stay frozen.
  - Re-enable ch0. Expect the first rise after re-enable only to arm, with new values published on the 2nd rise.
- Bus protocol:
  - Issue reads on consecutive cycles to addr 0, 13 and 20. Expect rd_valid high on 3 consecutive cycles, returning HI, 0x07 and 0x00.
  - Write 0xFF to CTRL. Expect a readback of 0x07.

Source files
------------

// File: rtl/pwm_in.sv
// Three-channel pulse-width capture: each synchronised pin yields a high-time and
// period measurement (in clocks) plus valid/overflow flags, all read over the 8-bit bus.
module pwm_in (
   input  logic       clk,
   input  logic       rst,
   input  logic       rd_en,
   input  logic [4:0] addr,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic [2:0] pin
);

   localparam logic [4:0] ADDR_STATUS = 5'd12;
   localparam logic [4:0] ADDR_CTRL   = 5'd13;
   localparam logic [7:0] CNT_MAX     = 8'd255;

   logic [2:0]      sync1_q, sync2_q, sdly_q;
   logic [2:0]      en_q, en_d;
   logic [2:0]      armed_q, armed_d;
   logic [2:0]      valid_q, valid_d;
   logic [2:0]      ovf_q, ovf_d;
   logic [2:0][7:0] cnt_q, cnt_d;
   logic [2:0][7:0] hi_run_q, hi_run_d;
   logic [2:0][7:0] hi_q, hi_d;
   logic [2:0][7:0] per_q, per_d;
   logic [7:0]      rd_data_q, rd_data_d;
   logic            rd_valid_q, rd_valid_d;

   logic [2:0] rise_s, fall_s, pub_s, ovf_set_s;
   logic [5:0] clr_s;
   logic [7:0] rd_mux_s;

   assign rise_s = sync2_q & ~sdly_q;
   assign fall_s = ~sync2_q & sdly_q;

   // Per-channel capture: a rise closes one period and publishes only once armed
   always_comb begin
      cnt_d     = cnt_q;
      hi_run_d  = hi_run_q;
      armed_d   = armed_q;
      hi_d      = hi_q;
      per_d     = per_q;
      pub_s     = 3'b000;
      ovf_set_s = 3'b000;
      for (int ch = 0; ch < 3; ch++) begin
         if (!en_q[ch]) begin
            cnt_d[ch]    = 8'd0;
            hi_run_d[ch] = 8'd0;
            armed_d[ch]  = 1'b0;
         end else if (rise_s[ch]) begin
            cnt_d[ch]   = 8'd1;
            armed_d[ch] = 1'b1;
            if (armed_q[ch]) begin
               pub_s[ch]     = 1'b1;
               per_d[ch]     = cnt_q[ch];
               hi_d[ch]      = hi_run_q[ch];
               ovf_set_s[ch] = (cnt_q[ch] == CNT_MAX) || (hi_run_q[ch] == CNT_MAX);
            end else begin
               pub_s[ch]     = 1'b0;
               ovf_set_s[ch] = 1'b0;
            end
         end else begin
            if (fall_s[ch]) begin
               hi_run_d[ch] = cnt_q[ch];
            end else begin
               hi_run_d[ch] = hi_run_q[ch];
            end
            cnt_d[ch] = (cnt_q[ch] == CNT_MAX) ? CNT_MAX : cnt_q[ch] + 8'd1;
         end
      end
   end

   // Status flags are write-1-to-clear, but a hardware set in the same cycle wins
   always_comb begin
      if (wr_en && (addr == ADDR_STATUS)) begin
         clr_s = wr_data[5:0];
      end else begin
         clr_s = 6'd0;
      end
      valid_d = (valid_q & ~clr_s[2:0]) | pub_s;
      ovf_d   = (ovf_q & ~clr_s[5:3]) | ovf_set_s;
      if (wr_en && (addr == ADDR_CTRL)) begin
         en_d = wr_data[2:0];
      end else begin
         en_d = en_q;
      end
   end

   // Read mux samples pre-update register state
   always_comb begin
      rd_mux_s = 8'h00;
      case (addr)
         5'd0:        rd_mux_s = hi_q[0];
         5'd1:        rd_mux_s = per_q[0];
         5'd4:        rd_mux_s = hi_q[1];
         5'd5:        rd_mux_s = per_q[1];
         5'd8:        rd_mux_s = hi_q[2];
         5'd9:        rd_mux_s = per_q[2];
         ADDR_STATUS: rd_mux_s = {2'b00, ovf_q, valid_q};
         ADDR_CTRL:   rd_mux_s = {5'b00000, en_q};
         default:     rd_mux_s = 8'h00;
      endcase
      if (rd_en) begin
         rd_data_d = rd_mux_s;
      end else begin
         rd_data_d = rd_data_q;
      end
      rd_valid_d = rd_en;
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= 3'b000;
         sync2_q    <= 3'b000;
         sdly_q     <= 3'b000;
         en_q       <= 3'b111;
         armed_q    <= 3'b000;
         valid_q    <= 3'b000;
         ovf_q      <= 3'b000;
         cnt_q      <= 24'd0;
         hi_run_q   <= 24'd0;
         hi_q       <= 24'd0;
         per_q      <= 24'd0;
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
      end else begin
         sync1_q    <= pin;
         sync2_q    <= sync1_q;
         sdly_q     <= sync2_q;
         en_q       <= en_d;
         armed_q    <= armed_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
         cnt_q      <= cnt_d;
         hi_run_q   <= hi_run_d;
         hi_q       <= hi_d;
         per_q      <= per_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule
